// File: rtl/approx_error_monitor_if.sv
// Sample stream and result bundle for approx_error_monitor.
// The sbias member exists only when ERR_BIAS_EN is defined.
interface approx_error_monitor_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 100,
    parameter int CNT_W  = 32
);
    logic                     start;
    logic                     stop;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_appx;
    logic signed [DATA_W-1:0] in_accr;
    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         sample_cnt;
    logic [CNT_W-1:0]         err_cnt;
    logic [DATA_W:0]          max_ae;
    logic [ACC_W-1:0]         sae;
    logic [ACC_W-1:0]         sse;
    logic                     acc_ovf;
`ifdef ERR_BIAS_EN
    logic signed [ACC_W-1:0]  sbias;
`endif

    modport master (
        output start, stop, in_valid, in_appx, in_accr,
        input  busy, done, sample_cnt, err_cnt, max_ae, sae, sse, acc_ovf
`ifdef ERR_BIAS_EN
        , input sbias
`endif
    );

    modport slave (
        input  start, stop, in_valid, in_appx, in_accr,
        output busy, done, sample_cnt, err_cnt, max_ae, sae, sse, acc_ovf
`ifdef ERR_BIAS_EN
        , output sbias
`endif
    );
endinterface

// File: rtl/approx_error_monitor.sv
// Streaming error-metric engine for approximate arithmetic units (count, errors, max/sum |AE|, sum AE^2).
// Define ERR_BIAS_EN to add the saturating signed bias accumulator sbias.
module approx_error_monitor #(
    parameter int DATA_W      = 32,
    parameter int ACC_W       = 100,
    parameter int CNT_W       = 32,
    parameter int NUM_SAMPLES = 0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    approx_error_monitor_if.slave bus
);
    localparam int SQW = 2 * DATA_W + 2;
    localparam int SW  = ((ACC_W > SQW) ? ACC_W : SQW) + 1;
    localparam logic [SW-1:0] ACC_MAX = {{(SW - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic             drain_q, drain_d;
    logic             s1_vld_q, s1_vld_d;
    logic [DATA_W:0]  diff_q, diff_d;
    logic             s2_vld_q, s2_vld_d;
    logic [DATA_W:0]  ae_q, ae_d;
    logic [SQW-1:0]   sq_q, sq_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [DATA_W:0]  max_ae_q, max_ae_d;
    logic [ACC_W-1:0] sae_q, sae_d;
    logic [ACC_W-1:0] sse_q, sse_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             auto_stop;
    logic [DATA_W:0]  diff_in;
    logic [SW-1:0]    sae_sum;
    logic [SW-1:0]    sse_sum;

`ifdef ERR_BIAS_EN
    localparam logic signed [SW-1:0] SB_MAX = {{(SW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] SB_MIN = ~SB_MAX;
    logic [DATA_W:0]         diff2_q, diff2_d;
    logic signed [ACC_W-1:0] sbias_q, sbias_d;
    logic signed [SW-1:0]    sb_sum;

    assign sb_sum = SW'(sbias_q) + SW'($signed(diff2_q));
`endif

    // start has priority, so a sample presented with start is never taken
    assign accept    = (state_q == RUN) && bus.in_valid && !bus.start;
    assign auto_stop = (NUM_SAMPLES != 0) && accept &&
                       (sample_cnt_q == CNT_W'(NUM_SAMPLES - 1));
    assign diff_in   = {bus.in_appx[DATA_W-1], bus.in_appx} - {bus.in_accr[DATA_W-1], bus.in_accr};
    assign sae_sum   = SW'(sae_q) + SW'(ae_q);
    assign sse_sum   = SW'(sse_q) + SW'(sq_q);

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        if (bus.start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (bus.stop || auto_stop) state_d = DRAIN;
                DRAIN: begin
                    drain_d = 1'b1;
                    if (drain_q) begin
                        state_d = DONE;
                        drain_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s1_vld_d = accept;
        diff_d   = accept ? diff_in : diff_q;
        s2_vld_d = s1_vld_q && !bus.start;
        ae_d     = ae_q;
        sq_d     = sq_q;
        if (s1_vld_q) begin
            ae_d = diff_q[DATA_W] ? (~diff_q + 1'b1) : diff_q;
            sq_d = SQW'(ae_d) * SQW'(ae_d);
        end
`ifdef ERR_BIAS_EN
        diff2_d = s1_vld_q ? diff_q : diff2_q;
`endif
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        max_ae_d     = max_ae_q;
        sae_d        = sae_q;
        sse_d        = sse_q;
        ovf_d        = ovf_q;
`ifdef ERR_BIAS_EN
        sbias_d      = sbias_q;
`endif
        if (accept) begin
            if (&sample_cnt_q) ovf_d = 1'b1;
            else               sample_cnt_d = sample_cnt_q + 1'b1;
        end
        if (s2_vld_q) begin
            if (ae_q != '0) begin
                if (&err_cnt_q) ovf_d = 1'b1;
                else            err_cnt_d = err_cnt_q + 1'b1;
            end
            if (ae_q > max_ae_q) max_ae_d = ae_q;
            if (sae_sum > ACC_MAX) begin
                sae_d = '1;
                ovf_d = 1'b1;
            end else begin
                sae_d = sae_sum[ACC_W-1:0];
            end
            if (sse_sum > ACC_MAX) begin
                sse_d = '1;
                ovf_d = 1'b1;
            end else begin
                sse_d = sse_sum[ACC_W-1:0];
            end
`ifdef ERR_BIAS_EN
            if (sb_sum > SB_MAX) begin
                sbias_d = SB_MAX[ACC_W-1:0];
                ovf_d   = 1'b1;
            end else if (sb_sum < SB_MIN) begin
                sbias_d = SB_MIN[ACC_W-1:0];
                ovf_d   = 1'b1;
            end else begin
                sbias_d = sb_sum[ACC_W-1:0];
            end
`endif
        end
        if (bus.start) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            max_ae_d     = '0;
            sae_d        = '0;
            sse_d        = '0;
            ovf_d        = 1'b0;
`ifdef ERR_BIAS_EN
            sbias_d      = '0;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            drain_q      <= 1'b0;
            s1_vld_q     <= 1'b0;
            diff_q       <= '0;
            s2_vld_q     <= 1'b0;
            ae_q         <= '0;
            sq_q         <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            max_ae_q     <= '0;
            sae_q        <= '0;
            sse_q        <= '0;
            ovf_q        <= 1'b0;
`ifdef ERR_BIAS_EN
            diff2_q      <= '0;
            sbias_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            s1_vld_q     <= s1_vld_d;
            diff_q       <= diff_d;
            s2_vld_q     <= s2_vld_d;
            ae_q         <= ae_d;
            sq_q         <= sq_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            max_ae_q     <= max_ae_d;
            sae_q        <= sae_d;
            sse_q        <= sse_d;
            ovf_q        <= ovf_d;
`ifdef ERR_BIAS_EN
            diff2_q      <= diff2_d;
            sbias_q      <= sbias_d;
`endif
        end
    end

    assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done       = (state_q == DONE);
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.max_ae     = max_ae_q;
    assign bus.sae        = sae_q;
    assign bus.sse        = sse_q;
    assign bus.acc_ovf    = ovf_q;
`ifdef ERR_BIAS_EN
    assign bus.sbias      = sbias_q;
`endif
endmodule
